// File: rtl/load_align_unit_if.sv
// Bus bundle for load_align_unit: request, memory-read and response handshakes.
// The unit connects through the slave modport; the environment uses master.
interface load_align_unit_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_resp_valid;
  logic [XLEN-1:0]   mem_resp_data;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_data;
  logic              resp_fault;

  modport slave (
    input  req_valid, req_funct3, req_addr, mem_req_ready, mem_resp_valid, mem_resp_data,
           resp_ready,
    output req_ready, mem_req_valid, mem_req_addr, resp_valid, resp_data, resp_fault
  );

  modport master (
    output req_valid, req_funct3, req_addr, mem_req_ready, mem_resp_valid, mem_resp_data,
           resp_ready,
    input  req_ready, mem_req_valid, mem_req_addr, resp_valid, resp_data, resp_fault
  );
endinterface

// File: rtl/load_align_unit.sv
// RISC-V load alignment unit: issues aligned word reads and returns the extended load result.
// Define LOAD_MISALIGNED_SPLIT_EN to serve misaligned loads (two beats when crossing a word).
module load_align_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input logic         clk,
  input logic         reset_n,
  load_align_unit_if.slave bus
);
  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);

  typedef enum logic [2:0] {StIdle, StIssue0, StWait0, StIssue1, StWait1, StDone} state_e;

  state_e            r_state, w_state_nxt;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_resp_data;
  logic              r_resp_fault;

  logic [OFFW-1:0]   w_req_off, w_off;
  logic [3:0]        w_bytes;
  logic              w_illegal, w_bad, w_accept, w_last_beat;
  logic [ADDR_W-1:0] w_aligned;
  logic [2*XLEN-1:0] w_cat;
  logic [63:0]       w_win, w_ext;
  logic [XLEN-1:0]   w_result;

  assign w_req_off = bus.req_addr[OFFW-1:0];
  assign w_bytes   = 4'd1 << bus.req_funct3[1:0];
  // LD (011) and LWU (110) only exist on a 64-bit datapath; 111 never exists.
  assign w_illegal = (bus.req_funct3 == 3'b111) ||
                     ((XLEN == 32) && ((bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110)));
  assign w_accept  = (r_state == StIdle) && bus.req_valid;
  assign w_aligned = r_addr & ~ADDR_W'(NB - 1);
  assign w_off     = r_addr[OFFW-1:0];

`ifdef LOAD_MISALIGNED_SPLIT_EN
  logic            r_cross;
  logic [XLEN-1:0] r_word0;
  logic [4:0]      w_req_end;
  logic            w_cross_req;

  assign w_req_end   = 5'(w_req_off) + 5'(w_bytes);
  assign w_cross_req = w_req_end > 5'(NB);
  assign w_bad       = w_illegal;
  assign w_cat       = (r_state == StWait1) ? {bus.mem_resp_data, r_word0}
                                            : {{XLEN{1'b0}}, bus.mem_resp_data};
  assign w_last_beat = bus.mem_resp_valid &&
                       ((r_state == StWait1) || ((r_state == StWait0) && !r_cross));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cross <= 1'b0;
      r_word0 <= '0;
    end else begin
      if (w_accept) r_cross <= w_cross_req;
      if ((r_state == StWait0) && bus.mem_resp_valid) r_word0 <= bus.mem_resp_data;
    end
  end
`else
  logic w_misal;

  assign w_misal     = (5'(w_req_off) & (5'(w_bytes) - 5'd1)) != 5'd0;
  assign w_bad       = w_illegal || w_misal;
  assign w_cat       = {{XLEN{1'b0}}, bus.mem_resp_data};
  assign w_last_beat = bus.mem_resp_valid && (r_state == StWait0);
`endif

  // Word1 sits above word0, so one right shift by the offset lines up both beats.
  assign w_win = 64'(w_cat >> {w_off, 3'b000});

  always_comb begin
    w_ext = w_win;
    unique case (r_funct3[1:0])
      2'b00:   w_ext = {{56{~r_funct3[2] & w_win[7]}}, w_win[7:0]};
      2'b01:   w_ext = {{48{~r_funct3[2] & w_win[15]}}, w_win[15:0]};
      2'b10:   w_ext = {{32{~r_funct3[2] & w_win[31]}}, w_win[31:0]};
      default: w_ext = w_win;
    endcase
  end

  assign w_result = XLEN'(w_ext);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:   if (bus.req_valid) w_state_nxt = w_bad ? StDone : StIssue0;
      StIssue0: if (bus.mem_req_ready) w_state_nxt = StWait0;
`ifdef LOAD_MISALIGNED_SPLIT_EN
      StWait0:  if (bus.mem_resp_valid) w_state_nxt = r_cross ? StIssue1 : StDone;
      StIssue1: if (bus.mem_req_ready) w_state_nxt = StWait1;
      StWait1:  if (bus.mem_resp_valid) w_state_nxt = StDone;
`else
      StWait0:  if (bus.mem_resp_valid) w_state_nxt = StDone;
`endif
      StDone:   if (bus.resp_ready) w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_funct3     <= '0;
      r_addr       <= '0;
      r_resp_data  <= '0;
      r_resp_fault <= 1'b0;
    end else begin
      if (w_accept) begin
        r_funct3     <= bus.req_funct3;
        r_addr       <= bus.req_addr;
        r_resp_data  <= '0;
        r_resp_fault <= w_bad;
      end
      if (w_last_beat) r_resp_data <= w_result;
    end
  end

  assign bus.req_ready = (r_state == StIdle);
`ifdef LOAD_MISALIGNED_SPLIT_EN
  assign bus.mem_req_valid = (r_state == StIssue0) || (r_state == StIssue1);
  assign bus.mem_req_addr  = (r_state == StIssue1) ? (w_aligned + ADDR_W'(NB)) :
                             (r_state == StIssue0) ? w_aligned : '0;
`else
  assign bus.mem_req_valid = (r_state == StIssue0);
  assign bus.mem_req_addr  = (r_state == StIssue0) ? w_aligned : '0;
`endif
  assign bus.resp_valid = (r_state == StDone);
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_fault = r_resp_fault;
endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Sequential load-data path between the execute stage and a word-wide data memory port.
- Accepts a RISC-V load request (funct3 + byte address) over a valid/ready handshake and issues one or two aligned memory reads.
- Extracts the addressed bytes and returns a sign- or zero-extended XLEN result with its own valid/ready handshake.
- Generalises the combinational load decoder with an XLEN parameter (32/64), LD/LWU support, backpressure and two-beat misaligned loads.

Parameters:
- XLEN, 32, datapath and memory word width; legal values 32 or 64.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  load request valid.
- req_ready  out  1  unit can accept a request.
- req_funct3  in  3  load type (RISC-V funct3 encoding).
- req_addr  in  ADDR_W  byte address.
- mem_req_valid  out  1  memory read request valid.
- mem_req_ready  in  1  memory accepts the read request.
- mem_req_addr  out  ADDR_W  word-aligned read address (low log2(XLEN/8) bits are 0).
- mem_resp_valid  in  1  read data valid; exactly one per accepted request.
- mem_resp_data  in  XLEN  read word.
- resp_valid  out  1  load result valid.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  XLEN  extended load result.
- resp_fault  out  1  illegal type or disallowed misalignment; qualified by resp_valid.

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; req_ready=1; mem_req_valid=0; mem_req_addr=0; resp_valid=0; resp_data=0; resp_fault=0. Reset mid-operation abandons the transaction. A mem_resp_valid arriving after reset is ignored.
- Load types:
  - 000 LB: 8-bit, sign-extended.
  - 001 LH: 16-bit, sign-extended.
  - 010 LW: 32-bit, sign-extended to XLEN.
  - 011 LD: 64-bit; legal only when XLEN=64.
  - 100 LBU: 8-bit, zero-extended.
  - 101 LHU: 16-bit, zero-extended.
  - 110 LWU: 32-bit, zero-extended; legal only when XLEN=64.
  - 111: always illegal.
- At XLEN=32, LW fills the full result width and no extension applies.
- Byte offset = req_addr mod (XLEN/8). Byte 0 is mem_resp_data[7:0] (little-endian).
- States: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, DONE.
- req_ready=1 only in IDLE. On req_valid&&req_ready the unit latches funct3 and address, then:
  - illegal type or disallowed misalignment -> DONE with fault;
  - otherwise -> ISSUE0.
- ISSUE0: mem_req_valid=1, mem_req_addr=aligned(addr). On mem_req_ready -> WAIT0.
- WAIT0: on mem_resp_valid, capture the word:
  - if the access crosses a word boundary -> ISSUE1;
  - else -> DONE.
- ISSUE1: mem_req_addr = aligned(addr)+XLEN/8; wraps modulo 2^ADDR_W. On mem_req_ready -> WAIT1.
- WAIT1: on mem_resp_valid, capture the second word -> DONE.
- Result assembly:
  - low bytes come from word0 starting at offset;
  - remaining high bytes come from word1 starting at byte 0;
  - result is extended per type.
- DONE: resp_valid=1. resp_data and resp_fault are registered and held stable until resp_ready. On resp_ready -> IDLE. No new request is accepted in the same cycle.
- Fault response: resp_data=0, resp_fault=1, no memory access issued.
- mem_req_valid, once asserted, stays high with a stable address until mem_req_ready.
- mem_resp_valid is ignored outside WAIT0/WAIT1.
- Latency with ready memory (mem_req_ready=1, response one cycle after acceptance):
  - request accepted at edge T;
  - mem_req_valid during cycle T+1;
  - data captured at T+2;
  - resp_valid from T+2 for aligned loads, T+4 for two-beat loads.

Optional Feature:
- Macro: LOAD_MISALIGNED_SPLIT_EN.
- Defined: a misaligned access that fits in one word uses one beat; one that crosses a word boundary uses two beats (ISSUE1/WAIT1).
- Undefined: any access not naturally aligned (LH offset odd, LW offset not multiple of 4, LD offset nonzero) faults with no memory request. ISSUE1/WAIT1 are not built.

Test Plan:
- XLEN=32, LB addr 0x1003, word 0x80123456 -> mem_req_addr 0x1000, resp_data 0xFFFFFF80; LBU at the same address -> 0x00000080.
- LH addr 0x1002, word 0xBFFF1234 -> 0xFFFFBFFF; LHU -> 0x0000BFFF; LW addr 0x1000, word 0xFFFFFFFF -> 0xFFFFFFFF.
- Split defined, LW addr 0x1001, words 0x44332211 @0x1000 and 0x88776655 @0x1004 -> two reads (0x1000 then 0x1004), resp_data 0x55443322, fault 0. Split undefined, same request -> resp_fault=1, resp_data 0, mem_req_valid never asserted.
- Backpressure: mem_req_ready low for 2 cycles, then resp_ready low for 3 cycles -> mem_req_addr held stable; resp_valid/resp_data held stable; req_ready=0 throughout; exactly one memory request issued per beat.
- Illegal funct3 111, and LD at XLEN=32 -> resp_fault=1 within 1 cycle of acceptance, no memory access. XLEN=64, LWU addr 0x2004, word 0xDEADBEEF_00000000 -> 0x00000000DEADBEEF.
- reset_n pulsed low during WAIT1 -> outputs at reset values immediately, req_ready=1; a stray mem_resp_valid afterwards produces no resp_valid.
